// File: rtl/bilinear_pkg.sv
// Shared constants and helpers for the bilinear interpolation pipe:
// pixel format encodings, per-format channel layout and rounding constant.
package bilinear_pkg;
  localparam int FMT_RGB565 = 0;
  localparam int FMT_RGB888 = 1;
  localparam int FMT_GRAY8  = 2;
  localparam int STAGES     = 3;

  function automatic int pix_w(input int fmt);
    case (fmt)
      FMT_RGB888: return 24;
      FMT_GRAY8:  return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic int num_ch(input int fmt);
    return (fmt == FMT_GRAY8) ? 1 : 3;
  endfunction

  // channel 0 is the most significant field (R for colour formats)
  function automatic int ch_w(input int fmt, input int c);
    if (fmt == FMT_RGB565) return (c == 1) ? 6 : 5;
    return 8;
  endfunction

  function automatic int ch_off(input int fmt, input int c);
    if (fmt == FMT_RGB565) return (c == 0) ? 11 : ((c == 1) ? 5 : 0);
    if (fmt == FMT_RGB888) return 16 - 8 * c;
    return 0;
  endfunction

  function automatic logic [63:0] round_const(input int frac, input int rnd);
    return (rnd != 0) ? (64'd1 << (frac - 1)) : 64'd0;
  endfunction
endpackage

// File: rtl/bilinear_chan_mac.sv
// One colour channel: registered weight*pixel products, then sum, round,
// shift back to pixel scale and clamp with a saturation flag.
module bilinear_chan_mac import bilinear_pkg::*; #(
  parameter int CH_W   = 5,
  parameter int COEF_W = 17,
  parameter int ROUND  = 1
)(
  input  logic                        vin_clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [3:0][2*COEF_W-1:0]    w,
  input  logic [3:0][CH_W-1:0]        pix,
  output logic [CH_W-1:0]             res,
  output logic                        sat
);
  localparam int F  = 2 * (COEF_W - 1);
  localparam int PW = CH_W + 2 * COEF_W;
  localparam int AW = PW + 2;
  // one extra bit so adding the rounding constant cannot wrap
  localparam int RW = AW + 1;
  localparam logic [RW-1:0] RC   = RW'(round_const(F, ROUND));
  localparam logic [RW-1:0] MAXV = RW'((64'd1 << CH_W) - 64'd1);

  logic [3:0][PW-1:0] prod;
  logic [AW-1:0]      acc;
  logic [RW-1:0]      q;

  always_ff @(posedge vin_clk or posedge rst)
    if (rst) prod <= '0;
    else if (en)
      for (int i = 0; i < 4; i++) prod[i] <= PW'(w[i]) * PW'(pix[i]);

  always_comb begin
    acc = AW'(prod[0]) + AW'(prod[1]) + AW'(prod[2]) + AW'(prod[3]);
    q   = (RW'(acc) + RC) >> F;
    sat = (q > MAXV);
    res = sat ? '1 : q[CH_W-1:0];
  end
endmodule

// File: rtl/bilinear_interp_pipe.sv
// Three-stage bilinear interpolator: S1 input/weight regs, S2 per-channel
// products, S3 sum/round/clamp into the output regs. Whole pipe freezes on stall.
module bilinear_interp_pipe import bilinear_pkg::*; #(
  parameter int          PIX_FMT  = 0,
  parameter int          COEF_W   = 17,
  parameter int          COORD_W  = 16,
  parameter int          ROUND    = 1,
  parameter logic [31:0] IDLE_DAT = 32'h0000_FF00,
  localparam int         PIX_W    = pix_w(PIX_FMT)
)(
  input  logic               vin_clk,
  input  logic               rst,
  input  logic               frame_sync_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [COEF_W-1:0]  coef1,
  input  logic [COEF_W-1:0]  coef2,
  input  logic [COEF_W-1:0]  coef3,
  input  logic [COEF_W-1:0]  coef4,
  input  logic [PIX_W-1:0]   pix00,
  input  logic [PIX_W-1:0]   pix01,
  input  logic [PIX_W-1:0]   pix10,
  input  logic [PIX_W-1:0]   pix11,
  output logic [COORD_W-1:0] vout_wr_x,
  output logic [COORD_W-1:0] vout_wr_y,
  output logic [PIX_W-1:0]   vout_wr_dat,
  output logic               vout_wr_valid,
  input  logic               vout_wr_ready,
  output logic [15:0]        sat_cnt
);
  localparam int NCH = num_ch(PIX_FMT);
  localparam int WW  = 2 * COEF_W;
  localparam logic [PIX_W-1:0] IDLE_PIX = IDLE_DAT[PIX_W-1:0];

  logic                     stall, flush, adv;
  logic [STAGES:1]          vld_pipe;
  logic [COORD_W-1:0]       x1, y1, x2, y2;
  logic [3:0][WW-1:0]       w1;
  logic [3:0][PIX_W-1:0]    p1;
  wire  [PIX_W-1:0]         dat_nxt;
  wire  [NCH-1:0]           ch_sat;

  assign stall    = vout_wr_valid && !vout_wr_ready;
  assign flush    = !frame_sync_n;
  assign adv      = !stall;
  assign in_ready = !stall || flush;
  assign vout_wr_valid = vld_pipe[STAGES];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam int CW  = ch_w(PIX_FMT, c);
    localparam int OFF = ch_off(PIX_FMT, c);
    bilinear_chan_mac #(.CH_W(CW), .COEF_W(COEF_W), .ROUND(ROUND)) u_mac (
      .vin_clk (vin_clk),
      .rst     (rst),
      .en      (adv),
      .w       (w1),
      .pix     ({p1[3][OFF +: CW], p1[2][OFF +: CW], p1[1][OFF +: CW], p1[0][OFF +: CW]}),
      .res     (dat_nxt[OFF +: CW]),
      .sat     (ch_sat[c])
    );
  end

  always_ff @(posedge vin_clk or posedge rst)
    if (rst) begin
      vld_pipe    <= '0;
      x1 <= '0; y1 <= '0; x2 <= '0; y2 <= '0;
      w1 <= '0; p1 <= '0;
      vout_wr_x   <= '0;
      vout_wr_y   <= '0;
      vout_wr_dat <= IDLE_PIX;
      sat_cnt     <= '0;
    end else if (flush) begin
      vld_pipe    <= '0;
      vout_wr_x   <= '0;
      vout_wr_y   <= '0;
      vout_wr_dat <= IDLE_PIX;
      sat_cnt     <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      x1 <= in_x;
      y1 <= in_y;
      w1 <= {WW'(coef2) * WW'(coef4), WW'(coef1) * WW'(coef4),
             WW'(coef2) * WW'(coef3), WW'(coef1) * WW'(coef3)};
      p1 <= {pix11, pix10, pix01, pix00};
      x2 <= x1;
      y2 <= y1;
      if (vld_pipe[STAGES-1]) begin
        vout_wr_x   <= x2;
        vout_wr_y   <= y2;
        vout_wr_dat <= dat_nxt;
        if (|ch_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
      end else begin
        vout_wr_x   <= '0;
        vout_wr_y   <= '0;
        vout_wr_dat <= IDLE_PIX;
      end
    end
endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// Scoreboard bench: an RGB565/round instance and an RGB888/truncate instance
// driven with hand-computed vectors; a negedge monitor checks every output.
module tb_bilinear_interp_pipe;
  typedef struct {
    logic [15:0] x, y;
    logic [23:0] dat;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  logic vin_clk = 0, rst = 0;
  int   cyc = 0;
  int   total = 0, bad = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  logic        fs0 = 1, iv0 = 0, ir0, ov0, or0 = 1;
  logic [15:0] ix0 = 0, iy0 = 0, ox0, oy0, sc0;
  logic [16:0] c10 = 0, c20 = 0, c30 = 0, c40 = 0;
  logic [15:0] p000 = 0, p010 = 0, p100 = 0, p110 = 0, od0;

  logic        fs1 = 1, iv1 = 0, ir1, ov1, or1 = 1;
  logic [15:0] ix1 = 0, iy1 = 0, ox1, oy1, sc1;
  logic [16:0] c11 = 0, c21 = 0, c31 = 0, c41 = 0;
  logic [23:0] p001 = 0, p011 = 0, p101 = 0, p111 = 0, od1;

  bilinear_interp_pipe #(.PIX_FMT(0), .ROUND(1)) d0 (
    .vin_clk(vin_clk), .rst(rst), .frame_sync_n(fs0), .in_valid(iv0), .in_ready(ir0),
    .in_x(ix0), .in_y(iy0), .coef1(c10), .coef2(c20), .coef3(c30), .coef4(c40),
    .pix00(p000), .pix01(p010), .pix10(p100), .pix11(p110),
    .vout_wr_x(ox0), .vout_wr_y(oy0), .vout_wr_dat(od0), .vout_wr_valid(ov0),
    .vout_wr_ready(or0), .sat_cnt(sc0));

  bilinear_interp_pipe #(.PIX_FMT(1), .ROUND(0)) d1 (
    .vin_clk(vin_clk), .rst(rst), .frame_sync_n(fs1), .in_valid(iv1), .in_ready(ir1),
    .in_x(ix1), .in_y(iy1), .coef1(c11), .coef2(c21), .coef3(c31), .coef4(c41),
    .pix00(p001), .pix01(p011), .pix10(p101), .pix11(p111),
    .vout_wr_x(ox1), .vout_wr_y(oy1), .vout_wr_dat(od1), .vout_wr_valid(ov1),
    .vout_wr_ready(or1), .sat_cnt(sc1));

  always #5 vin_clk = ~vin_clk;
  always @(posedge vin_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic send(input int d, input int x, input int y,
                      input int k1, input int k2, input int k3, input int k4,
                      input logic [23:0] a, input logic [23:0] b,
                      input logic [23:0] c, input logic [23:0] dd,
                      input logic [23:0] exp_dat, input bit push, input bit lat);
    exp_t e;
    int   n = 0;
    logic rdy;
    if (d == 0) begin
      ix0 = x[15:0]; iy0 = y[15:0];
      c10 = k1[16:0]; c20 = k2[16:0]; c30 = k3[16:0]; c40 = k4[16:0];
      p000 = a[15:0]; p010 = b[15:0]; p100 = c[15:0]; p110 = dd[15:0];
      iv0 = 1;
    end else begin
      ix1 = x[15:0]; iy1 = y[15:0];
      c11 = k1[16:0]; c21 = k2[16:0]; c31 = k3[16:0]; c41 = k4[16:0];
      p001 = a; p011 = b; p101 = c; p111 = dd;
      iv1 = 1;
    end
    do begin
      @(posedge vin_clk);
      rdy = (d == 0) ? ir0 : ir1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=0 required=1 x=%0d", x);
    end else if (push) begin
      e.x = x[15:0]; e.y = y[15:0]; e.dat = exp_dat; e.acc_cyc = cyc; e.lat = lat;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    #1;
    if (d == 0) iv0 = 0; else iv1 = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge vin_clk);
      n++;
    end
    chk("drain_pending", 64'(q0.size() + q1.size()), 0);
    q0.delete(); q1.delete();
    repeat (2) @(posedge vin_clk);
    #2;
  endtask

  // monitor: pop/compare on every transfer, check idle outputs and stall backpressure
  always @(negedge vin_clk) begin
    if (!rst) begin
      if (ov0) begin
        if (!or0) chk("stall_in_ready0", ir0, 0);
        else if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out0 actual_x=%0d dat=%0h required=none", ox0, od0);
        end else begin
          e0 = q0.pop_front();
          chk("x0", ox0, e0.x);
          chk("y0", oy0, e0.y);
          chk("dat0", od0, e0.dat[15:0]);
          if (e0.lat) chk("latency0", 64'(cyc - e0.acc_cyc), 3);
        end
      end else chk("idle_dat0", {ox0, oy0, od0}, {32'h0, 16'hFF00});
      if (ov1) begin
        if (!or1) chk("stall_in_ready1", ir1, 0);
        else if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out1 actual_x=%0d dat=%0h required=none", ox1, od1);
        end else begin
          e1 = q1.pop_front();
          chk("x1", ox1, e1.x);
          chk("y1", oy1, e1.y);
          chk("dat1", od1, e1.dat);
          if (e1.lat) chk("latency1", 64'(cyc - e1.acc_cyc), 3);
        end
      end else chk("idle_dat1", {ox1, oy1, od1}, {32'h0, 24'h00FF00});
    end
  end

  initial begin
    #1 rst = 1;
    repeat (2) @(posedge vin_clk);
    #2;
    chk("rst_valid0", ov0, 0);
    chk("rst_dat0", od0, 16'hFF00);
    chk("rst_xy0", {ox0, oy0}, 0);
    chk("rst_sat0", sc0, 0);
    chk("rst_dat1", od1, 24'h00FF00);
    chk("rst_in_ready0", ir0, 1);
    rst = 0;
    @(posedge vin_clk); #1;

    // pass-through, rounding, over-unity without clamp, exact-max boundary
    send(0, 1, 1, 65536, 0, 65536, 0, 16'hF81F, 0, 0, 0, 16'hF81F, 1, 1);
    send(0, 2, 1, 32768, 32768, 32768, 32768, 0, 16'h001F, 0, 16'h001F, 16'h0010, 1, 0);
    send(0, 3, 1, 32768, 32768, 32768, 32768, 16'hFFFF, 0, 0, 0, 16'h4208, 1, 0);
    send(0, 4, 1, 65536, 0, 65536, 0, 16'hFFFF, 0, 0, 0, 16'hFFFF, 1, 0);
    send(0, 8, 1, 65536, 65536, 65536, 0, 16'h0841, 16'h0841, 0, 0, 16'h1082, 1, 0);
    send(1, 100, 7, 65536, 0, 0, 65536, 0, 0, 24'h123456, 0, 24'h123456, 1, 1);
    send(1, 101, 7, 32768, 32768, 32768, 32768, 0, 24'h00001F, 0, 24'h00001F, 24'h00000F, 1, 0);
    send(1, 102, 7, 32768, 32768, 32768, 32768, 24'hFFFFFF, 0, 0, 0, 24'h3F3F3F, 1, 0);
    drain();
    chk("sat_none0", sc0, 0);
    chk("sat_none1", sc1, 0);

    // saturating pixels
    for (int i = 0; i < 3; i++)
      send(0, 5 + i, 2, 65536, 65536, 65536, 65536, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
           16'hFFFF, 1, 0);
    send(1, 103, 7, 65536, 65536, 65536, 65536, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
         24'hFFFFFF, 24'hFFFFFF, 1, 0);
    drain();
    chk("sat_cnt3", sc0, 3);
    chk("sat_cnt1", sc1, 1);

    // burst with downstream stall mid-burst
    fork
      begin
        send(0, 10, 3, 65536, 0, 65536, 0, 16'h1111, 0, 0, 0, 16'h1111, 1, 0);
        send(0, 11, 3, 65536, 0, 65536, 0, 16'h2222, 0, 0, 0, 16'h2222, 1, 0);
        send(0, 12, 3, 65536, 0, 65536, 0, 16'h3333, 0, 0, 0, 16'h3333, 1, 0);
        send(0, 13, 3, 65536, 0, 65536, 0, 16'h4444, 0, 0, 0, 16'h4444, 1, 0);
      end
      begin
        repeat (3) @(posedge vin_clk);
        #1 or0 = 0;
        repeat (2) @(posedge vin_clk);
        #1 or0 = 1;
      end
    join
    drain();

    // frame flush with two saturating beats in flight
    for (int i = 0; i < 2; i++)
      send(0, 20 + i, 4, 65536, 65536, 65536, 65536, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
           16'hFFFF, 1, 0);
    drain();
    chk("sat_cnt5", sc0, 5);
    send(0, 30, 5, 65536, 65536, 65536, 65536, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    send(0, 31, 5, 65536, 65536, 65536, 65536, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    fs0 = 0;
    @(posedge vin_clk); #1;
    fs0 = 1;
    chk("flush_sat", sc0, 0);
    chk("flush_dat", od0, 16'hFF00);
    chk("flush_valid", ov0, 0);
    repeat (6) @(posedge vin_clk);
    #1 chk("flush_sat_after", sc0, 0);

    // async reset with a stalled burst in the RGB888 instance
    or1 = 0;
    for (int i = 0; i < 3; i++)
      send(1, 110 + i, 8, 65536, 0, 0, 65536, 0, 0, 24'hABCDEF, 0, 0, 0, 0);
    #3 rst = 1;
    #1;
    chk("arst_valid1", ov1, 0);
    chk("arst_dat1", od1, 24'h00FF00);
    chk("arst_xy1", {ox1, oy1}, 0);
    chk("arst_sat1", sc1, 0);
    chk("arst_in_ready1", ir1, 1);
    @(posedge vin_clk); #1;
    rst = 0;
    or1 = 1;
    repeat (6) @(posedge vin_clk);
    #1;
    chk("final_queues", 64'(q0.size() + q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
